// File: rtl/alu_sbm_seq_pkg.sv
// Shared types and helpers for the bit-sliced ALU issue sequencer.
package alu_sbm_seq_pkg;

    // ALU operation encoding shared with the 16-bit slice
    typedef enum logic [3:0] {
        ALU_OP_ADD    = 4'd0,
        ALU_OP_SUB    = 4'd1,
        ALU_OP_PLUS_4 = 4'd2,
        ALU_OP_AND    = 4'd3,
        ALU_OP_OR     = 4'd4,
        ALU_OP_XOR    = 4'd5,
        ALU_OP_SLL    = 4'd6,
        ALU_OP_SRL    = 4'd7,
        ALU_OP_SRA    = 4'd8,
        ALU_OP_EQ     = 4'd9,
        ALU_OP_LT     = 4'd10,
        ALU_OP_LTU    = 4'd11
    } cs_alu_op;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_B1   = 2'd1,
        SEQ_B2   = 2'd2,
        SEQ_RESP = 2'd3
    } seq_state_e;

    // Right shifts walk from the top half down so bits spill into the low half
    function automatic logic alu_op_high_first(input cs_alu_op op);
        return (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
    endfunction

    // Ops whose answer is a single compare bit
    function automatic logic alu_op_is_cmp(input cs_alu_op op);
        return (op == ALU_OP_EQ) || (op == ALU_OP_LT) || (op == ALU_OP_LTU);
    endfunction

    // Ops that take a shift amount instead of a B operand
    function automatic logic alu_op_is_shift(input cs_alu_op op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
    endfunction

endpackage

// File: rtl/alu_sbm_seq_premap.sv
// Operand premap: folds the >=16 part of a 32-bit shift into a half-word move
// so the 16-bit slice only ever shifts by 0..15.
module alu_sbm_seq_premap
    import alu_sbm_seq_pkg::*;
(
    input  cs_alu_op    op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] a_prime,
    output logic [31:0] b_prime,
    output logic [3:0]  amt
);

    // Half-word pre-shift of A for shift amounts of 16 or more
    always_comb begin
        a_prime = a;
        b_prime = b;
        amt     = b[3:0];
        case (op)
            ALU_OP_SLL: begin
                if (b[4]) begin
                    a_prime = {a[15:0], 16'h0000};
                end
            end
            ALU_OP_SRL: begin
                if (b[4]) begin
                    a_prime = {16'h0000, a[31:16]};
                end
            end
            ALU_OP_SRA: begin
                if (b[4]) begin
                    a_prime = {{16{a[31]}}, a[31:16]};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sbm_seq.sv
// Issue-side sequencer: splits a 32-bit ALU request into two 16-bit beats
// for the bit-sliced ALU and reassembles the result onto a valid/ready port.
module alu_sbm_seq
    import alu_sbm_seq_pkg::*;
#(
    parameter bit EQ_EARLY_EXIT = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  cs_alu_op    req_op,
    input  logic        req_cmp_flip,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_cmp,
    output logic        alu_first_cycle,
    output cs_alu_op    alu_op,
    output logic        alu_cmp_flip,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_cmp_result,
    input  logic        alu_cmp_result_valid
);

    seq_state_e  state_reg;
    logic        high_first_reg;
    logic [15:0] a_hold_reg;
    logic [15:0] b_hold_reg;

    logic [31:0] a_prime;
    logic [31:0] b_prime;
    logic [3:0]  amt;

    logic        req_high_first;
    logic        req_is_shift;
    logic [15:0] a_first;
    logic [15:0] a_second;
    logic [15:0] b_first;
    logic [15:0] b_second;

    logic [31:0] merged_result;
    logic [31:0] final_result;
    logic        op_is_cmp;
    logic        cmp_now;
    logic        early_exit;

    alu_sbm_seq_premap u_premap (
        .op      (req_op),
        .a       (req_a),
        .b       (req_b),
        .a_prime (a_prime),
        .b_prime (b_prime),
        .amt     (amt)
    );

    // Split the premapped operands into first/second beat halves
    always_comb begin
        req_high_first = alu_op_high_first(req_op);
        req_is_shift   = alu_op_is_shift(req_op);
        a_first        = req_high_first ? a_prime[31:16] : a_prime[15:0];
        a_second       = req_high_first ? a_prime[15:0]  : a_prime[31:16];
        if (req_is_shift) begin
            b_first  = {12'h000, amt};
            b_second = {12'h000, amt};
        end else begin
            b_first  = req_high_first ? b_prime[31:16] : b_prime[15:0];
            b_second = req_high_first ? b_prime[15:0]  : b_prime[31:16];
        end
    end

    // Merge the current beat's slice output and decide whether EQ can finish now
    always_comb begin
        merged_result = rsp_result;
        // The beat touches the high half in B1 when high-first, else in B2
        if ((state_reg == SEQ_B1) == high_first_reg) begin
            merged_result[31:16] = alu_result;
        end else begin
            merged_result[15:0] = alu_result;
        end
        op_is_cmp    = alu_op_is_cmp(alu_op);
        cmp_now      = (op_is_cmp && alu_cmp_result_valid) ? alu_cmp_result : rsp_cmp;
        final_result = op_is_cmp ? {31'h0, cmp_now} : merged_result;
        early_exit   = EQ_EARLY_EXIT && (state_reg == SEQ_B1) &&
                       (alu_op == ALU_OP_EQ) && alu_cmp_result_valid;
    end

    // Sequencer FSM with registered slice drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= SEQ_IDLE;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_result      <= 32'h0;
            rsp_cmp         <= 1'b0;
            alu_first_cycle <= 1'b0;
            alu_op          <= ALU_OP_AND;
            alu_cmp_flip    <= 1'b0;
            alu_a           <= 16'h0;
            alu_b           <= 16'h0;
            high_first_reg  <= 1'b0;
            a_hold_reg      <= 16'h0;
            b_hold_reg      <= 16'h0;
        end else begin
            case (state_reg)
                SEQ_IDLE: begin
                    if (req_valid) begin
                        state_reg       <= SEQ_B1;
                        req_ready       <= 1'b0;
                        rsp_cmp         <= 1'b0;
                        alu_first_cycle <= 1'b1;
                        alu_op          <= req_op;
                        alu_cmp_flip    <= req_cmp_flip;
                        alu_a           <= a_first;
                        alu_b           <= b_first;
                        high_first_reg  <= req_high_first;
                        a_hold_reg      <= a_second;
                        b_hold_reg      <= b_second;
                    end
                end
                SEQ_B1: begin
                    alu_first_cycle <= 1'b0;
                    rsp_cmp         <= cmp_now;
                    if (early_exit) begin
                        state_reg    <= SEQ_RESP;
                        rsp_valid    <= 1'b1;
                        rsp_result   <= final_result;
                        alu_op       <= ALU_OP_AND;
                        alu_cmp_flip <= 1'b0;
                        alu_a        <= 16'h0;
                        alu_b        <= 16'h0;
                    end else begin
                        state_reg  <= SEQ_B2;
                        rsp_result <= merged_result;
                        alu_a      <= a_hold_reg;
                        alu_b      <= b_hold_reg;
                    end
                end
                SEQ_B2: begin
                    // AND with first_cycle low leaves the slice state untouched
                    state_reg    <= SEQ_RESP;
                    rsp_valid    <= 1'b1;
                    rsp_result   <= final_result;
                    rsp_cmp      <= cmp_now;
                    alu_op       <= ALU_OP_AND;
                    alu_cmp_flip <= 1'b0;
                    alu_a        <= 16'h0;
                    alu_b        <= 16'h0;
                end
                SEQ_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= SEQ_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= SEQ_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sbm_seq.sv
// Testbench for alu_sbm_seq: a behavioural 16-bit slice closes the loop and a
// 32-bit reference model fills a scoreboard that is checked at each response.
module tb_alu_sbm_seq;
    import alu_sbm_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    cs_alu_op    req_op;
    logic        req_cmp_flip;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cmp;
    logic        alu_first_cycle;
    cs_alu_op    alu_op;
    logic        alu_cmp_flip;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_cmp_result;
    logic        alu_cmp_result_valid;

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    alu_sbm_seq #(.EQ_EARLY_EXIT(1'b1)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_op               (req_op),
        .req_cmp_flip         (req_cmp_flip),
        .req_a                (req_a),
        .req_b                (req_b),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_result           (rsp_result),
        .rsp_cmp              (rsp_cmp),
        .alu_first_cycle      (alu_first_cycle),
        .alu_op               (alu_op),
        .alu_cmp_flip         (alu_cmp_flip),
        .alu_a                (alu_a),
        .alu_b                (alu_b),
        .alu_result           (alu_result),
        .alu_cmp_result       (alu_cmp_result),
        .alu_cmp_result_valid (alu_cmp_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural 16-bit slice ----------------
    logic [15:0] sl_spill_reg, sl_spill_next;
    logic        sl_carry_reg, sl_carry_next;
    logic        sl_eq_reg, sl_eq_next;
    logic        sl_lt_reg, sl_lt_next;
    logic [16:0] sl_sum;
    logic [31:0] sl_wide;
    logic [3:0]  sl_amt;
    logic        sl_lt_hi;

    always_comb begin
        alu_result           = 16'h0;
        alu_cmp_result       = 1'b0;
        alu_cmp_result_valid = 1'b0;
        sl_sum               = 17'h0;
        sl_wide              = 32'h0;
        sl_lt_hi             = 1'b0;
        sl_amt               = alu_b[3:0];
        sl_carry_next        = sl_carry_reg;
        sl_spill_next        = sl_spill_reg;
        sl_eq_next           = sl_eq_reg;
        sl_lt_next           = sl_lt_reg;
        case (alu_op)
            ALU_OP_ADD: begin
                sl_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, (alu_first_cycle ? 1'b0 : sl_carry_reg)};
                alu_result = sl_sum[15:0];
                sl_carry_next = sl_sum[16];
            end
            ALU_OP_SUB: begin
                sl_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'h0, (alu_first_cycle ? 1'b1 : sl_carry_reg)};
                alu_result = sl_sum[15:0];
                sl_carry_next = sl_sum[16];
            end
            ALU_OP_PLUS_4: begin
                sl_sum = {1'b0, alu_a} + (alu_first_cycle ? 17'd4 : {16'h0, sl_carry_reg});
                alu_result = sl_sum[15:0];
                sl_carry_next = sl_sum[16];
            end
            ALU_OP_AND: alu_result = alu_a & alu_b;
            ALU_OP_OR:  alu_result = alu_a | alu_b;
            ALU_OP_XOR: alu_result = alu_a ^ alu_b;
            ALU_OP_SLL: begin
                sl_wide = {16'h0, alu_a} << sl_amt;
                alu_result = sl_wide[15:0] | (alu_first_cycle ? 16'h0 : sl_spill_reg);
                sl_spill_next = sl_wide[31:16];
            end
            ALU_OP_SRL: begin
                sl_wide = {alu_a, 16'h0} >> sl_amt;
                alu_result = sl_wide[31:16] | (alu_first_cycle ? 16'h0 : sl_spill_reg);
                sl_spill_next = sl_wide[15:0];
            end
            ALU_OP_SRA: begin
                if (alu_first_cycle) begin
                    sl_wide = $signed({alu_a, 16'h0}) >>> sl_amt;
                    alu_result = sl_wide[31:16];
                end else begin
                    sl_wide = {alu_a, 16'h0} >> sl_amt;
                    alu_result = sl_wide[31:16] | sl_spill_reg;
                end
                sl_spill_next = sl_wide[15:0];
            end
            ALU_OP_EQ: begin
                if (alu_first_cycle) begin
                    alu_cmp_result_valid = (alu_a != alu_b);
                    alu_cmp_result = alu_cmp_flip;
                    sl_eq_next = (alu_a == alu_b);
                end else begin
                    alu_cmp_result_valid = 1'b1;
                    alu_cmp_result = (sl_eq_reg && (alu_a == alu_b)) ^ alu_cmp_flip;
                end
            end
            ALU_OP_LT, ALU_OP_LTU: begin
                if (alu_first_cycle) begin
                    sl_lt_next = (alu_a < alu_b);
                end else begin
                    sl_lt_hi = (alu_op == ALU_OP_LT) ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);
                    alu_cmp_result_valid = 1'b1;
                    alu_cmp_result = ((alu_a == alu_b) ? sl_lt_reg : sl_lt_hi) ^ alu_cmp_flip;
                end
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        sl_carry_reg <= sl_carry_next;
        sl_spill_reg <= sl_spill_next;
        sl_eq_reg    <= sl_eq_next;
        sl_lt_reg    <= sl_lt_next;
    end

    // ---------------- 32-bit reference: {cmp, result} ----------------
    function automatic logic [32:0] ref_calc(input cs_alu_op op, input logic flip,
                                             input logic [31:0] a, input logic [31:0] b);
        logic c;
        case (op)
            ALU_OP_ADD:    return {1'b0, a + b};
            ALU_OP_SUB:    return {1'b0, a - b};
            ALU_OP_PLUS_4: return {1'b0, a + 32'd4};
            ALU_OP_AND:    return {1'b0, a & b};
            ALU_OP_OR:     return {1'b0, a | b};
            ALU_OP_XOR:    return {1'b0, a ^ b};
            ALU_OP_SLL:    return {1'b0, a << b[4:0]};
            ALU_OP_SRL:    return {1'b0, a >> b[4:0]};
            ALU_OP_SRA:    return {1'b0, 32'($signed(a) >>> b[4:0])};
            ALU_OP_EQ: begin
                c = (a == b) ^ flip;
                return {c, 31'h0, c};
            end
            ALU_OP_LT: begin
                c = ($signed(a) < $signed(b)) ^ flip;
                return {c, 31'h0, c};
            end
            ALU_OP_LTU: begin
                c = (a < b) ^ flip;
                return {c, 31'h0, c};
            end
            default: return 33'h0;
        endcase
    endfunction

    // Drive one request (called at a negedge); returns at the negedge of beat 1
    task automatic issue(input cs_alu_op op, input logic flip,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] r;
        int          n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        req_valid    = 1'b1;
        req_op       = op;
        req_cmp_flip = flip;
        req_a        = a;
        req_b        = b;
        r            = ref_calc(op, flip, a, b);
        e.res        = r[31:0];
        e.cmp        = r[32];
        e.lat        = (op == ALU_OP_EQ && a[15:0] != b[15:0]) ? 2 : 3;
        e.t_acc      = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for a response, pop the scoreboard and compare; consumes the response
    task automatic collect(input string name, input logic chk_lat);
        exp_t e;
        int   n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: queue empty, required an entry", name);
            return;
        end
        e = sb_q.pop_front();
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: rsp_valid=%b required 1", name, rsp_valid);
        end
        if (chk_lat) begin
            checks++;
            if ((cyc - e.t_acc) != e.lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d required %0d", name, cyc - e.t_acc, e.lat);
            end
        end
        checks++;
        if (rsp_result !== e.res) begin
            errors++;
            $display("FAIL %s_result: got %h required %h", name, rsp_result, e.res);
        end
        checks++;
        if (rsp_cmp !== e.cmp) begin
            errors++;
            $display("FAIL %s_cmp: got %b required %b", name, rsp_cmp, e.cmp);
        end
        $display("txn %s: result=%h cmp=%b lat=%0d", name, rsp_result, rsp_cmp, cyc - e.t_acc);
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: rsp_valid=%b req_ready=%b required 0/1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 32'h0 || rsp_cmp !== 1'b0) begin
            errors++;
            $display("FAIL %s_rsp: req_ready=%b rsp_valid=%b rsp_result=%h rsp_cmp=%b required 1/0/0/0",
                     name, req_ready, rsp_valid, rsp_result, rsp_cmp);
        end
        checks++;
        if (alu_first_cycle !== 1'b0 || alu_op !== ALU_OP_AND || alu_cmp_flip !== 1'b0 ||
            alu_a !== 16'h0 || alu_b !== 16'h0) begin
            errors++;
            $display("FAIL %s_alu: first=%b op=%0d flip=%b a=%h b=%h required 0/%0d/0/0/0",
                     name, alu_first_cycle, alu_op, alu_cmp_flip, alu_a, alu_b, ALU_OP_AND);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        $display("txn reset: outputs at reset values checked");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        issue(ALU_OP_ADD, 1'b0, 32'h0000FFFF, 32'h00000001);
        checks++;
        if (alu_first_cycle !== 1'b1 || alu_a !== 16'hFFFF || alu_op !== ALU_OP_ADD) begin
            errors++;
            $display("FAIL add_beat1: first=%b a=%h op=%0d required 1/ffff/%0d", alu_first_cycle, alu_a, alu_op, ALU_OP_ADD);
        end
        @(negedge clk);
        checks++;
        if (alu_first_cycle !== 1'b0 || alu_a !== 16'h0000) begin
            errors++;
            $display("FAIL add_beat2: first=%b a=%h required 0/0000", alu_first_cycle, alu_a);
        end
        collect("add_carry", 1'b1);
    endtask

    task automatic test_sub();
        issue(ALU_OP_SUB, 1'b0, 32'h00000000, 32'h00000001);
        collect("sub_wrap", 1'b1);
        issue(ALU_OP_SUB, 1'b0, 32'h00010000, 32'h00000001);
        collect("sub_borrow", 1'b1);
    endtask

    task automatic test_misc_ops();
        issue(ALU_OP_PLUS_4, 1'b0, 32'h0000FFFE, 32'h12345678);
        collect("plus4", 1'b1);
        issue(ALU_OP_AND, 1'b0, 32'hF0F0A5A5, 32'hFF00FFFF);
        collect("and", 1'b1);
        issue(ALU_OP_OR, 1'b0, 32'h12340000, 32'h00005678);
        collect("or", 1'b1);
        issue(ALU_OP_XOR, 1'b0, 32'hAAAA5555, 32'hFFFF0000);
        collect("xor", 1'b1);
    endtask

    task automatic test_shift();
        issue(ALU_OP_SRA, 1'b0, 32'h80000000, 32'd20);
        checks++;
        if (alu_a !== 16'hFFFF || alu_b !== 16'h0004 || alu_first_cycle !== 1'b1) begin
            errors++;
            $display("FAIL sra_beat1: a=%h b=%h first=%b required ffff/0004/1", alu_a, alu_b, alu_first_cycle);
        end
        @(negedge clk);
        checks++;
        if (alu_a !== 16'h8000 || alu_b !== 16'h0004) begin
            errors++;
            $display("FAIL sra_beat2: a=%h b=%h required 8000/0004", alu_a, alu_b);
        end
        collect("sra20", 1'b1);
        issue(ALU_OP_SRL, 1'b0, 32'h80000000, 32'd4);
        collect("srl4", 1'b1);
        issue(ALU_OP_SRL, 1'b0, 32'h87654321, 32'hFFFFFFF3);
        collect("srl19_bigb", 1'b1);
        issue(ALU_OP_SLL, 1'b0, 32'h00000001, 32'd31);
        collect("sll31", 1'b1);
        issue(ALU_OP_SLL, 1'b0, 32'h00018000, 32'd1);
        collect("sll1", 1'b1);
    endtask

    task automatic test_compare();
        issue(ALU_OP_EQ, 1'b0, 32'h12345678, 32'h12345679);
        collect("eq_early", 1'b1);
        issue(ALU_OP_EQ, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
        collect("eq_equal", 1'b1);
        issue(ALU_OP_EQ, 1'b1, 32'h1234BEEF, 32'h5678BEEF);
        collect("ne_hi_diff", 1'b1);
        issue(ALU_OP_LT, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        collect("lt_signed", 1'b1);
        issue(ALU_OP_LTU, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        collect("ltu", 1'b1);
        issue(ALU_OP_LT, 1'b1, 32'hFFFFFFFF, 32'h00000001);
        collect("ge_flip", 1'b1);
        issue(ALU_OP_LTU, 1'b0, 32'h00050001, 32'h00050002);
        collect("ltu_lo_decides", 1'b1);
    endtask

    task automatic test_unknown();
        cs_alu_op bad_op;
        bad_op = cs_alu_op'(4'd15);
        issue(bad_op, 1'b0, 32'hCAFEF00D, 32'h00000003);
        collect("unknown_op", 1'b1);
    endtask

    task automatic test_back_to_back();
        cs_alu_op    op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 12; i++) begin
            op = cs_alu_op'($urandom_range(0, 11));
            a  = $urandom;
            b  = $urandom;
            if (i % 3 == 0) b[15:0] = a[15:0];
            issue(op, 1'($urandom_range(0, 1)), a, b);
            collect($sformatf("b2b_%0d_op%0d", i, op), 1'b1);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_res;
        int          n;
        rsp_ready = 1'b0;
        issue(ALU_OP_ADD, 1'b0, 32'h11111111, 32'h22222222);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        exp_res = sb_q[0].res;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== exp_res || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: valid=%b result=%h req_ready=%b required 1/%h/0",
                         i, rsp_valid, rsp_result, req_ready, exp_res);
            end
            @(negedge clk);
        end
        collect("backpressure", 1'b0);
    endtask

    task automatic test_reset_mid();
        issue(ALU_OP_SUB, 1'b0, 32'h00000005, 32'h00000007);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_b2");
        $display("txn reset_mid_b2: request aborted");
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(ALU_OP_SUB, 1'b0, 32'h00000005, 32'h00000007);
        collect("after_reset", 1'b1);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = ALU_OP_ADD;
        req_cmp_flip = 1'b0;
        req_a        = 32'h0;
        req_b        = 32'h0;
        rsp_ready    = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_misc_ops();
        test_shift();
        test_compare();
        test_unknown();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sbm_seq.md
Name: alu_sbm_seq

Overview:
- Issue-side sequencer for the 16-bit bit-sliced ALU.
- Accepts one 32-bit ALU request per handshake and splits the operands into two 16-bit beats. Drives the slice's first_cycle, op, cmp_flip and operand halves, then reassembles the 32-bit result or compare bit.
- Returns the result on a valid/ready response channel. Sits between decode/issue and the ALU slice in the execute stage.

Parameters:
- EQ_EARLY_EXIT, 1: when 1, finish EQ after beat 1 if alu_cmp_result_valid is high in beat 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accept
- req_op  in  cs_alu_op  operation
- req_cmp_flip  in  1  invert compare sense (NE/GE/GEU)
- req_a  in  32  operand A
- req_b  in  32  operand B; shifts use req_b[4:0]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_result  out  32  result; compares return {31'b0, cmp}
- rsp_cmp  out  1  compare outcome
- alu_first_cycle  out  1  beat-1 marker to slice
- alu_op  out  cs_alu_op  op to slice
- alu_cmp_flip  out  1  flip to slice
- alu_a  out  16  A half to slice
- alu_b  out  16  B half to slice
- alu_result  in  16  slice result half
- alu_cmp_result  in  1  slice compare bit
- alu_cmp_result_valid  in  1  slice compare valid

Behaviour:
- FSM states and transitions:
  - IDLE -> B1 on req_valid & req_ready.
  - B1 -> B2 unconditionally, except B1 -> RESP on EQ early exit.
  - B2 -> RESP.
  - RESP -> IDLE on rsp_ready.
- req_ready = (state == IDLE). No new request is accepted in B1/B2/RESP.
- Throughput and latency:
  - Accept in cycle T: beat 1 in T+1, beat 2 in T+2, rsp_valid from T+3.
  - EQ early exit: rsp_valid from T+2.
- On accept, register op, flip, A' and B'. The request inputs are not used afterwards.
- Shift premap. Let n = req_b[4:0]; shift amount presented is amt = n[3:0].
  - SRL/SRA, n < 16: A' = req_a.
  - SRL/SRA, n >= 16: A' = {fill, req_a[31:16]}, where fill = 0x0000 for SRL and {16{req_a[31]}} for SRA.
  - SLL, n < 16: A' = req_a.
  - SLL, n >= 16: A' = {req_a[15:0], 0x0000}.
  - For all shifts, alu_b = {12'b0, amt} in both beats, so alu_b[4] is always 0.
- Beat order:
  - SRL/SRA: high half first.
  - All other ops (ADD, SUB, PLUS_4, AND, OR, XOR, SLL, EQ, LT, LTU): low half first.
- Operand halves per beat:
  - Non-shift ops: alu_a = A' half, alu_b = B' half.
  - Shifts: alu_a = A' half, alu_b fixed as above.
- alu_first_cycle:
  - 1 only in B1; 0 in IDLE, B2 and RESP.
  - This keeps the slice carry register cleared between operations.
- alu_op:
  - Registered op in B1 and B2.
  - ALU_OP_AND in IDLE and RESP, which causes no slice state update.
- alu_cmp_flip: registered flip in B1/B2; 0 otherwise.
- Result capture:
  - Each beat writes alu_result into the half it processed.
  - For EQ/LT/LTU, rsp_cmp takes alu_cmp_result in the beat where alu_cmp_result_valid = 1, and rsp_result = {31'b0, rsp_cmp}.
  - For non-compare ops, rsp_cmp = 0.
- rsp_result and rsp_cmp are registered and stay stable while rsp_valid & !rsp_ready.
- Reset values, applied asynchronously at any state including mid-beat:
  - state = IDLE, req_ready = 1, rsp_valid = 0.
  - rsp_result = 0, rsp_cmp = 0.
  - alu_first_cycle = 0, alu_op = ALU_OP_AND, alu_cmp_flip = 0, alu_a = alu_b = 0.
- Unknown op: processed as two beats, result = captured halves (slice returns 0).

Decomposition:
- Package typedefs gains:
  - seq_state_e {SEQ_IDLE, SEQ_B1, SEQ_B2, SEQ_RESP}
  - function alu_op_high_first(cs_alu_op)
  - function alu_op_is_cmp(cs_alu_op)
- cs_alu_op is reused unchanged.
- One sub-module: alu_sbm_seq_premap, combinational; computes A', B' and amt from op/a/b.

Test Plan:
- ADD 0x0000FFFF + 0x00000001 -> rsp_result 0x00010000 at T+3.
  - Beat 1: alu_a = 0xFFFF, alu_first_cycle = 1.
  - Beat 2: alu_a = 0x0000, alu_first_cycle = 0.
- SUB 0x00000000 - 0x00000001 -> 0xFFFFFFFF; SUB 0x00010000 - 1 -> 0x0000FFFF.
- SRA 0x80000000 by 20 -> 0xFFFFF800.
  - Beat 1 alu_a = 0xFFFF, beat 2 alu_a = 0x8000, alu_b = 0x0004.
  - SRL 0x80000000 by 4 -> 0x08000000.
- SLL 0x00000001 by 31 -> 0x80000000; SLL 0x00018000 by 1 -> 0x00030000.
- EQ 0x12345678 vs 0x12345679 -> rsp_cmp 0 at T+2 (early exit).
  - LT 0xFFFFFFFF vs 1 -> 1; LTU same operands -> 0; LT with flip -> 0.
- Back-pressure and reset:
  - rsp_ready low 5 cycles -> rsp_result stable, req_ready 0.
  - rst_n low during B2 -> all outputs at reset values within the same cycle; the next request completes correctly.
